// File: rtl/btn_debounce_pulse.sv
// Push-button front end: two-flop synchroniser, shared sample-tick divider,
// per-button debounce, press pulse generation and optional hold-to-repeat.
module btn_debounce_pulse #(
    parameter int                 NUM_BTN     = 4,
    parameter int                 SAMPLE_DIV  = 500000,
    parameter int                 DEB_SAMPLES = 4,
    parameter int                 REPEAT_DLY  = 50,
    parameter int                 REPEAT_PER  = 10,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(4'b0110)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [NUM_BTN-1:0] BAP_BTN,
    output logic [NUM_BTN-1:0] BTN_LEVEL
);

    localparam int CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DEB_W     = $clog2(DEB_SAMPLES + 1);
    localparam int HOLD_MAXV = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HOLD_W    = $clog2(HOLD_MAXV + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] DLY_V   = HOLD_W'(REPEAT_DLY);
    localparam logic [HOLD_W-1:0] PER_V   = HOLD_W'(REPEAT_PER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;

    // Shared sample-tick divider and two-flop input synchroniser (next state).
    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        sync1_d = BTN;
        sync2_d = sync1_q;
    end

    // Divider and synchroniser registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            localparam bit RPT_EN = REPEAT_MASK[gi];

            logic              level_q, level_d;
            logic              prev_q, prev_d;
            logic              bap_q, bap_d;
            logic [DEB_W-1:0]  deb_q, deb_d;
            logic [HOLD_W-1:0] hold_q, hold_d;
            rpt_state_t        st_q, st_d;
            logic              rise;
            logic              rpt_pulse;

            // Debounce: the stable level flips only after DEB_SAMPLES
            // consecutive ticks on which the synced input disagrees with it.
            always_comb begin
                level_d = level_q;
                deb_d   = deb_q;
                prev_d  = level_q;
                if (tick) begin
                    if (sync2_q[gi] == level_q) begin
                        deb_d = '0;
                    end else if (deb_q == DEB_MAX) begin
                        level_d = ~level_q;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
            end

            // Repeat FSM next state and pulse generation; a falling level
            // (seen on level_d) forces IDLE before any repeat pulse can fire.
            always_comb begin
                rise      = level_q & ~prev_q;
                st_d      = st_q;
                hold_d    = hold_q;
                rpt_pulse = 1'b0;
                if (!RPT_EN || !level_d) begin
                    st_d   = ST_IDLE;
                    hold_d = '0;
                end else begin
                    case (st_q)
                        ST_IDLE: begin
                            if (rise) begin
                                st_d   = ST_WAIT;
                                hold_d = '0;
                            end
                        end
                        ST_WAIT: begin
                            if (hold_q == DLY_V) begin
                                rpt_pulse = 1'b1;
                                st_d      = ST_RPT;
                                hold_d    = '0;
                            end else if (tick) begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end
                        ST_RPT: begin
                            if (hold_q == PER_V) begin
                                rpt_pulse = 1'b1;
                                hold_d    = '0;
                            end else if (tick) begin
                                hold_d = hold_q + HOLD_W'(1);
                            end
                        end
                        default: begin
                            st_d   = ST_IDLE;
                            hold_d = '0;
                        end
                    endcase
                end
                bap_d = rise | rpt_pulse;
            end

            // Per-button state registers.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    level_q <= 1'b0;
                    prev_q  <= 1'b0;
                    bap_q   <= 1'b0;
                    deb_q   <= '0;
                    hold_q  <= '0;
                    st_q    <= ST_IDLE;
                end else begin
                    level_q <= level_d;
                    prev_q  <= prev_d;
                    bap_q   <= bap_d;
                    deb_q   <= deb_d;
                    hold_q  <= hold_d;
                    st_q    <= st_d;
                end
            end

            assign BTN_LEVEL[gi] = level_q;
            assign BAP_BTN[gi]   = bap_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Testbench for btn_debounce_pulse: directed scenarios plus random button
// activity, compared every cycle against an event-level reference model.
module tb_btn_debounce_pulse;

    localparam int         DIV  = 4;
    localparam int         DEB  = 3;
    localparam int         DLY  = 5;
    localparam int         PER  = 2;
    localparam logic [3:0] MASK = 4'b0001;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] BTN, BAP, LVL;
    logic [3:0] BTN2, BAP2, LVL2;

    always #5 CLK = ~CLK;

    btn_debounce_pulse #(
        .NUM_BTN(4), .SAMPLE_DIV(DIV), .DEB_SAMPLES(DEB),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_MASK(MASK)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BTN(BTN), .BAP_BTN(BAP), .BTN_LEVEL(LVL)
    );

    btn_debounce_pulse #(
        .NUM_BTN(4), .SAMPLE_DIV(1), .DEB_SAMPLES(1)
    ) dut_fast (
        .CLK(CLK), .RESET(RESET), .BTN(BTN2), .BAP_BTN(BAP2), .BTN_LEVEL(LVL2)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [3:0] m_s1, m_s2, m_lvl, m_bap;
    int         m_run [4];
    int         m_rise[4];
    bit         m_rv  [4];
    int         m_n;
    int         m_edge = 0;
    bit         m_tk;

    // observation bookkeeping
    int pc[4];
    int fp[4];
    int fp2;
    int pq0[$];
    bit lvl_hi1;

    // Reference: level flips after DEB disagreeing ticks; pulses occur one
    // edge after a rise, and for repeat buttons at fixed tick multiples later.
    task automatic model_update();
        m_edge++;
        if (RESET) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_bap = '0; m_n = 0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_rv[i] = 0; m_rise[i] = 0;
            end
        end else begin
            m_tk = (m_n == DIV - 1);
            m_n  = m_tk ? 0 : m_n + 1;
            for (int i = 0; i < 4; i++) begin
                if (m_tk) begin
                    if (m_s2[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_lvl[i] = ~m_lvl[i];
                            m_run[i] = 0;
                            m_rv[i]  = m_lvl[i];
                            if (m_lvl[i]) m_rise[i] = m_edge;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = BTN;
            for (int i = 0; i < 4; i++) begin
                int d;
                d = m_edge - m_rise[i] - 1 - DIV * DLY;
                m_bap[i] = m_rv[i] && ((m_edge == m_rise[i] + 1) ||
                           (MASK[i] && d >= 0 && (d % (DIV * PER)) == 0));
            end
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0; fp[i] = -1;
        end
        fp2 = -1;
        pq0.delete();
        lvl_hi1 = 1'b0;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_update();
            #1;
            tests++;
            assert ({BAP, LVL} === {m_bap, m_lvl}) else begin
                fails++;
                $error("FAIL model_cmp edge %0d: bap=%b lvl=%b required bap=%b lvl=%b",
                       m_edge, BAP, LVL, m_bap, m_lvl);
            end
            for (int i = 0; i < 4; i++) begin
                if (BAP[i] === 1'b1) begin
                    pc[i]++;
                    if (fp[i] < 0) fp[i] = m_edge;
                end
            end
            if (BAP[0] === 1'b1) pq0.push_back(m_edge);
            if (BAP2[0] === 1'b1 && fp2 < 0) fp2 = m_edge;
            if (LVL[1] === 1'b1) lvl_hi1 = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
        $display("[TB] check %s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int e0, lat, n, i0, i1;
        RESET = 1'b1; BTN = '0; BTN2 = '0;
        clr();
        step(3);
        chk("reset_bap", int'(BAP), 0);
        chk("reset_lvl", int'(LVL), 0);
        RESET = 1'b0;

        // 1: single press on a non-repeat button, latency window, silent release
        clr(); e0 = m_edge; BTN[2] = 1'b1;
        step(100);
        lat = fp[2] - e0;
        chk("t1_pulse_count", pc[2], 1);
        chk("t1_latency_ok", int'(lat >= 11 && lat <= 15), 1);
        chk("t1_level_high", int'(LVL[2]), 1);
        clr(); BTN[2] = 1'b0;
        step(40);
        chk("t1_release_pulses", pc[2], 0);
        chk("t1_level_low", int'(LVL[2]), 0);

        // 2: chatter shorter than the debounce window, then a steady hold
        clr();
        for (int k = 0; k < 10; k++) begin
            BTN[1] = ~BTN[1];
            step(6);
        end
        chk("t2_chatter_pulses", pc[1], 0);
        chk("t2_level_stable", int'(lvl_hi1), 0);
        BTN[1] = 1'b1;
        step(40);
        chk("t2_hold_pulses", pc[1], 1);
        BTN[1] = 1'b0;
        step(40);

        // 3: hold-to-repeat on button 0, button 3 masked off
        clr(); BTN[0] = 1'b1; BTN[3] = 1'b1;
        step(200);
        n  = pq0.size();
        i0 = (n >= 3) ? pq0[1] - pq0[0] : -1;
        i1 = (n >= 3) ? pq0[2] - pq0[1] : -1;
        chk("t3_enough_pulses", int'(n >= 3), 1);
        chk("t3_first_repeat_gap", i0, DIV * DLY);
        chk("t3_repeat_period", i1, DIV * PER);
        chk("t3_masked_single", pc[3], 1);
        BTN[0] = 1'b0; BTN[3] = 1'b0;
        step(20);
        clr();
        step(20);
        chk("t3_stop_after_release", pc[0] + pc[3], 0);

        // 4: simultaneous press and release of all buttons
        clr(); BTN = 4'b1111;
        step(40);
        chk("t4_b0_pulsed", int'(fp[0] > 0), 1);
        chk("t4_b1_same_cycle", fp[1], fp[0]);
        chk("t4_b2_same_cycle", fp[2], fp[0]);
        chk("t4_b3_same_cycle", fp[3], fp[0]);
        clr(); BTN = 4'b0000;
        step(40);
        chk("t4_release_no_pulse", pc[1] + pc[2] + pc[3], 0);
        chk("t4_levels_low", int'(LVL), 0);

        // 5: reset while button 0 is auto-repeating
        BTN[0] = 1'b1;
        step(50);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        chk("t5_reset_bap", int'(BAP), 0);
        chk("t5_reset_lvl", int'(LVL), 0);
        clr(); e0 = m_edge;
        step(20);
        chk("t5_repress_in_time", int'(fp[0] > e0 && fp[0] - e0 <= 15), 1);
        BTN[0] = 1'b0;
        step(40);

        // 6: divide-by-1, single-sample build: fixed 4-cycle latency
        for (int r = 0; r < 3; r++) begin
            clr(); e0 = m_edge; BTN2[0] = 1'b1;
            step(6);
            chk("t6_latency", fp2 - e0, 4);
            chk("t6_no_x", int'($isunknown({BAP2, LVL2})), 0);
            BTN2[0] = 1'b0;
            step($urandom_range(3, 9));
        end

        // random button activity, checked cycle by cycle against the model
        for (int r = 0; r < 30; r++) begin
            BTN = 4'($urandom);
            step($urandom_range(1, 25));
        end
        BTN = '0;
        step(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
